e203_ifu_rfrd_arb: RTL
======================

E203_IFU_RFRD_ARB -- requirements
Module: e203_ifu_rfrd_arb

Interface
REQ-001 Parameter: XLEN, default 32, register data width.
REQ-002 Parameter: RFIDX_W, default 5, register index width.
REQ-003 Parameter: STARVE_LIM, default 4, count of consecutive BPU-denied cycles after which BPU wins; range 1..15.
REQ-004 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  the single clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 bpu_req  in  1  BPU JALR-rs1 read request; held until granted or flushed.
REQ-008 bpu_idx  in  RFIDX_W  BPU read index; stable while bpu_req is high.
REQ-009 exu_req  in  1  EXU operand read request; may change every cycle.
REQ-010 exu_idx  in  RFIDX_W  EXU read index.
REQ-011 flush  in  1  pipeline flush; kills pending and in-flight BPU reads.
REQ-012 bpu_gnt  out  1  BPU request accepted this cycle.
REQ-013 exu_gnt  out  1  EXU request accepted this cycle.
REQ-014 rf_rd_ena  out  1  regfile read port 1 enable.
REQ-015 rf_rd_idx  out  RFIDX_W  regfile read port 1 index.
REQ-016 rf_rd_data  in  XLEN  read port 1 data, valid the cycle after rf_rd_ena.
REQ-017 bpu_rsp_vld  out  1  one-cycle pulse: bpu_rsp_data valid.
REQ-018 bpu_rsp_data  out  XLEN  BPU read result.
REQ-019 exu_rsp_vld  out  1  one-cycle pulse: exu_rsp_data valid.
REQ-020 exu_rsp_data  out  XLEN  EXU read result.
REQ-021 bpu_starved  out  1  starvation counter reached STARVE_LIM.

Function
REQ-022 At most one of bpu_gnt/exu_gnt SHALL be high in any cycle.
REQ-023 Default priority: EXU wins when both request; BPU is granted when exu_req is low.
REQ-024 Starvation counter: increments (saturating at STARVE_LIM) each cycle bpu_req is high, bpu_gnt is low and flush is low; clears on bpu_gnt, flush, or bpu_req low.
REQ-025 When the counter equals STARVE_LIM, bpu_starved is high and BPU wins over EXU that cycle.
REQ-026 Grant is combinational in the request cycle; a granted read issues rf_rd_ena=1 and rf_rd_idx = the winner's index in that same cycle.
REQ-027 Index 0 bypass: a grant with index 0 keeps rf_rd_ena=0, and the response returns data 0 with the normal 1-cycle latency.
REQ-028 Owner FSM, registered, states NONE/BPU/EXU: next = BPU on bpu_gnt, EXU on exu_gnt, else NONE; a zero-flag register records the index-0 bypass.
REQ-029 Response timing: in the cycle after a grant, the owner's rsp_vld SHALL pulse for exactly one cycle; data is rf_rd_data, or 0 if zero-flagged.
REQ-030 Latency SHALL be 1 cycle from grant to response; back-to-back grants every cycle are allowed (full throughput).
REQ-031 flush asserted SHALL force bpu_gnt=0 that cycle; if the owner state is BPU, bpu_rsp_vld is suppressed and the state returns to NONE.
REQ-032 flush SHALL NOT affect EXU grant or response.
REQ-033 The non-owner response data output SHALL be 0; rsp_vld SHALL be low when the owner is NONE.
REQ-034 A request with no grant SHALL NOT alter rf_rd_idx-derived state; when no grant is given, rf_rd_idx = 0.

Reset
REQ-035 While rst is high: owner=NONE, zero-flag=0, counter=0, and all outputs 0 (including grants, with requests masked).
REQ-036 Reset asserted the cycle after a grant SHALL suppress that response; the first grant is possible in the first cycle after rst deasserts.

Verification
REQ-037 bpu_req=1, bpu_idx=5, exu_req=0 -> bpu_gnt=1 and rf_rd_idx=5 in cycle 0; rf_rd_data=0xDEAD_BEEF -> bpu_rsp_vld=1 with data 0xDEAD_BEEF in cycle 1 only.
REQ-038 bpu_req=1 and exu_req=1 every cycle, STARVE_LIM=4 -> exu_gnt for cycles 0-3; bpu_starved=1 and bpu_gnt=1 in cycle 4; counter=0 in cycle 5.
REQ-039 exu_req=1, exu_idx=0 -> rf_rd_ena=0 and exu_gnt=1; next cycle exu_rsp_vld=1, exu_rsp_data=0 even with rf_rd_data=0xFFFF_FFFF.
REQ-040 BPU granted in cycle 0, flush=1 in cycle 1 -> bpu_rsp_vld=0 in cycle 1; an EXU grant in cycle 1 is unaffected and responds in cycle 2.
REQ-041 Alternating EXU (idx 3) and BPU (idx 7) grants on consecutive cycles -> responses alternate each cycle with no bubbles, each routed to its owner.
REQ-042 rst=1 in the cycle after an exu_gnt -> exu_rsp_vld=0 and all outputs 0 until rst deasserts.

Source files
------------

// File: rtl/e203_ifu_rfrd_arb.sv
// Regfile read-port-1 arbiter between the BPU (JALR rs1) and the EXU.
// Grants combinationally and returns data one cycle later, with x0 bypass.
module e203_ifu_rfrd_arb #(
    parameter int XLEN       = 32,
    parameter int RFIDX_W    = 5,
    parameter int STARVE_LIM = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bpu_req,
    input  logic [RFIDX_W-1:0] bpu_idx,
    input  logic               exu_req,
    input  logic [RFIDX_W-1:0] exu_idx,
    input  logic               flush,
    output logic               bpu_gnt,
    output logic               exu_gnt,
    output logic               rf_rd_ena,
    output logic [RFIDX_W-1:0] rf_rd_idx,
    input  logic [XLEN-1:0]    rf_rd_data,
    output logic               bpu_rsp_vld,
    output logic [XLEN-1:0]    bpu_rsp_data,
    output logic               exu_rsp_vld,
    output logic [XLEN-1:0]    exu_rsp_data,
    output logic               bpu_starved
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_BPU  = 2'd1;
    localparam logic [1:0] OWN_EXU  = 2'd2;
    localparam logic [3:0] LIM      = 4'(STARVE_LIM);

    logic [1:0]      owner_q;
    logic [1:0]      owner_d;
    logic            zflag_q;
    logic            zflag_d;
    logic [3:0]      cnt_q;
    logic [3:0]      cnt_d;
    logic            bpu_win;
    logic            any_gnt;
    logic [XLEN-1:0] rsp_data;

    always_comb begin
        bpu_starved = ~rst & (cnt_q == LIM);
        // Starvation lets BPU jump EXU, but a flush always kills the BPU read.
        bpu_win     = bpu_req & ~flush & (~exu_req | bpu_starved);
        bpu_gnt     = ~rst & bpu_win;
        exu_gnt     = ~rst & exu_req & ~bpu_win;
        any_gnt     = bpu_gnt | exu_gnt;
        rf_rd_idx   = '0;
        unique case (1'b1)
            bpu_gnt: rf_rd_idx = bpu_idx;
            exu_gnt: rf_rd_idx = exu_idx;
            default: rf_rd_idx = '0;
        endcase
        rf_rd_ena   = any_gnt & (rf_rd_idx != '0);
        zflag_d     = any_gnt & (rf_rd_idx == '0);
    end

    always_comb begin
        owner_d = OWN_NONE;
        unique case (1'b1)
            bpu_gnt: owner_d = OWN_BPU;
            exu_gnt: owner_d = OWN_EXU;
            default: owner_d = OWN_NONE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (bpu_req & ~bpu_gnt & ~flush) begin
            cnt_d = (cnt_q == LIM) ? cnt_q : cnt_q + 4'd1;
        end
    end

    always_comb begin
        rsp_data     = zflag_q ? '0 : rf_rd_data;
        bpu_rsp_vld  = ~rst & ~flush & (owner_q == OWN_BPU);
        exu_rsp_vld  = ~rst & (owner_q == OWN_EXU);
        bpu_rsp_data = bpu_rsp_vld ? rsp_data : '0;
        exu_rsp_data = exu_rsp_vld ? rsp_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OWN_NONE;
            zflag_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            zflag_q <= zflag_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
